// File: rtl/dinosaur_sprite.sv
// dinosaur_sprite: jump physics and 32x32 bitmap pixel source for the VGA stage.
// The jump state (GROUND/RISE/FALL, height, velocity) advances once per frame
// on the rising edge of vs. The pixel output is combinational on the
// registered VGA addresses. Optional macro DINO_LEG_ANIM_EN alternates the leg
// rows every 8 idle frames.
module dinosaur_sprite #(
    parameter int X0         = 64,
    parameter int GROUND_ROW = 400,
    parameter int JUMP_V     = 14
) (
    input  logic       vga_clk,
    input  logic       clrn,
    input  logic [8:0] row_addr,
    input  logic [9:0] col_addr,
    input  logic       rdn,
    input  logic       vs,
    input  logic       jump,
    input  logic       freeze,
    output logic       px_dinosaur,
    output logic [8:0] dino_top,
    output logic       airborne
);

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } state_t;

    localparam logic [4:0] JV       = 5'(JUMP_V);
    localparam logic [8:0] TOP_REST = 9'(GROUND_ROW - 32);
    localparam logic [9:0] X_LEFT   = 10'(X0);
    localparam logic [9:0] X_RIGHT  = 10'(X0 + 32);
    localparam logic [4:0] X_LOW    = 5'(X0);

    logic       vs_q;
    logic       tick;
    logic       jump_s1, jump_s2, jump_s3;
    logic       jump_edge;
    logic       pending;
    state_t     state, state_nxt;
    logic [7:0] height, height_nxt;
    logic [4:0] vel, vel_nxt;
    logic       leg_b;

    // Frame tick: one cycle at the rising edge of vertical sync.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours; blocking here would chain flops together.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) vs_q <= 1'b0;
        else       vs_q <= vs;
    end

    assign tick = vs & ~vs_q;

    // Two-flop synchronizer for the asynchronous button, plus an edge-detect flop.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            jump_s1 <= 1'b0;
            jump_s2 <= 1'b0;
            jump_s3 <= 1'b0;
        end else begin
            jump_s1 <= jump;
            jump_s2 <= jump_s1;
            jump_s3 <= jump_s2;
        end
    end

    assign jump_edge = jump_s2 & ~jump_s3;

    // Press request: set by a button edge, dropped on every frame tick.
    // A press arriving on the tick cycle itself is kept for the next frame.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn)          pending <= 1'b0;
        else if (jump_edge) pending <= 1'b1;
        else if (tick)      pending <= 1'b0;
    end

    // Jump state machine: next state, height and velocity for this frame.
    // NOTE: every output is given its hold value first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt  = state;
        height_nxt = height;
        vel_nxt    = vel;
        if (tick && !freeze) begin
            case (state)
                GROUND: begin
                    if (pending) begin
                        state_nxt = RISE;
                        vel_nxt   = JV;
                    end
                end
                RISE: begin
                    height_nxt = height + {3'b000, vel};
                    if (vel == 5'd1) begin
                        state_nxt = FALL;
                        vel_nxt   = 5'd1;
                    end else begin
                        vel_nxt = vel - 5'd1;
                    end
                end
                FALL: begin
                    if (height <= {3'b000, vel}) begin
                        height_nxt = 8'd0;
                        vel_nxt    = 5'd0;
                        state_nxt  = GROUND;
                    end else begin
                        height_nxt = height - {3'b000, vel};
                        vel_nxt    = (vel >= JV) ? JV : vel + 5'd1;
                    end
                end
                default: begin
                    state_nxt  = GROUND;
                    height_nxt = 8'd0;
                    vel_nxt    = 5'd0;
                end
            endcase
        end
    end

    // State register; dino_top and airborne are derived from the next values
    // so they move in the same cycle as height.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            state    <= GROUND;
            height   <= 8'd0;
            vel      <= 5'd0;
            dino_top <= TOP_REST;
            airborne <= 1'b0;
        end else begin
            state    <= state_nxt;
            height   <= height_nxt;
            vel      <= vel_nxt;
            dino_top <= TOP_REST - {1'b0, height_nxt};
            airborne <= (state_nxt != GROUND);
        end
    end

`ifdef DINO_LEG_ANIM_EN
    logic [2:0] frame_cnt;
    logic       leg_phase;

    // Idle leg animation: count ground frames, flip the leg phase on wrap.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            frame_cnt <= 3'd0;
            leg_phase <= 1'b0;
        end else if (tick && !freeze && state == GROUND) begin
            frame_cnt <= frame_cnt + 3'd1;
            if (frame_cnt == 3'd7) leg_phase <= ~leg_phase;
        end
    end

    assign leg_b = leg_phase & (state == GROUND);
`else
    assign leg_b = 1'b0;
`endif

    // Bitmap, MSB is the leftmost pixel. Rows 26-31 are the legs.
    // NOTE: the sprite is a constant lookup, not a storage array, so there is
    // nothing to reset; the pixel is valid straight out of reset.
    function automatic logic [31:0] rom_row(input logic [4:0] r, input logic alt);
        logic [31:0] w;
        w = 32'h0000_0000;
        case (r)
            5'd0:  w = 32'h0000_7FF0;
            5'd1:  w = 32'h0000_FFF8;
            5'd2:  w = 32'h0000_CFF8;
            5'd3:  w = 32'h0000_FFFF;
            5'd4:  w = 32'h0000_FFFF;
            5'd5:  w = 32'h0000_FFF8;
            5'd6:  w = 32'h0000_FC00;
            5'd7:  w = 32'h0000_FFC0;
            5'd8:  w = 32'h0001_FC00;
            5'd9:  w = 32'h8003_FC00;
            5'd10: w = 32'h800F_FC00;
            5'd11: w = 32'hC01F_FF00;
            5'd12: w = 32'hE03F_FD00;
            5'd13: w = 32'hF0FF_FC00;
            5'd14: w = 32'hFFFF_FC00;
            5'd15: w = 32'hFFFF_FC00;
            5'd16: w = 32'h7FFF_FC00;
            5'd17: w = 32'h3FFF_F800;
            5'd18: w = 32'h1FFF_F800;
            5'd19: w = 32'h0FFF_F000;
            5'd20: w = 32'h07FF_E000;
            5'd21: w = 32'h03FF_C000;
            5'd22: w = 32'h01FF_8000;
            5'd23: w = 32'h00FF_0000;
            5'd24: w = 32'h007E_0000;
            5'd25: w = 32'h0066_0000;
            5'd26: w = alt ? 32'h0066_0000 : 32'h0062_0000;
            5'd27: w = alt ? 32'h0046_0000 : 32'h0062_0000;
            5'd28: w = alt ? 32'h0044_0000 : 32'h0042_0000;
            5'd29: w = alt ? 32'h0064_0000 : 32'h0043_0000;
            5'd30: w = alt ? 32'h0006_0000 : 32'h0060_0000;
            5'd31: w = alt ? 32'h0007_0000 : 32'h0070_0000;
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    logic [9:0]  row_ext, top_ext;
    logic        in_box;
    logic [4:0]  rom_r, rom_c;
    logic [31:0] rom_word;

    // Pixel path: box test in 10-bit unsigned, then a ROM bit lookup.
    // The low five address bits suffice for the offsets once in_box holds.
    always_comb begin
        row_ext     = {1'b0, row_addr};
        top_ext     = {1'b0, dino_top};
        in_box      = (row_ext >= top_ext) && (row_ext < top_ext + 10'd32) &&
                      (col_addr >= X_LEFT) && (col_addr < X_RIGHT);
        rom_r       = row_addr[4:0] - dino_top[4:0];
        rom_c       = col_addr[4:0] - X_LOW;
        rom_word    = rom_row(rom_r, leg_b);
        px_dinosaur = ~rdn & in_box & rom_word[5'd31 - rom_c];
    end

endmodule

// File: tb/tb_dinosaur_sprite.sv
// Directed bench for dinosaur_sprite: reset, pixel bounds, leg animation,
// full jump trajectory, dropped double jump, freeze and mid-jump reset.
// Expected leg-row pixels follow DINO_LEG_ANIM_EN when it is defined.
module tb_dinosaur_sprite;

    logic       vga_clk = 1'b0;
    logic       clrn;
    logic [8:0] row_addr;
    logic [9:0] col_addr;
    logic       rdn;
    logic       vs;
    logic       jump;
    logic       freeze;
    logic       px_dinosaur;
    logic [8:0] dino_top;
    logic       airborne;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] ROW0  = 32'h0000_7FF0;
    localparam logic [31:0] LEG_A = 32'h0070_0000;
    localparam logic [31:0] LEG_B = 32'h0007_0000;

    // Heights after each RISE tick and each FALL tick for JUMP_V=14.
    int rise_h [14] = '{14, 27, 39, 50, 60, 69, 77, 84, 90, 95, 99, 102, 104, 105};
    int fall_h [14] = '{104, 102, 99, 95, 90, 84, 77, 69, 60, 50, 39, 27, 14, 0};

    dinosaur_sprite #(.X0(64), .GROUND_ROW(400), .JUMP_V(14)) dut (
        .vga_clk     (vga_clk),
        .clrn        (clrn),
        .row_addr    (row_addr),
        .col_addr    (col_addr),
        .rdn         (rdn),
        .vs          (vs),
        .jump        (jump),
        .freeze      (freeze),
        .px_dinosaur (px_dinosaur),
        .dino_top    (dino_top),
        .airborne    (airborne)
    );

    always #20 vga_clk = ~vga_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame: vs high for a few cycles then low; returns on a falling edge.
    task automatic do_tick();
        @(negedge vga_clk);
        vs = 1'b1;
        repeat (3) @(negedge vga_clk);
        vs = 1'b0;
        repeat (3) @(negedge vga_clk);
    endtask

    task automatic press();
        @(negedge vga_clk);
        jump = 1'b1;
        repeat (4) @(negedge vga_clk);
        jump = 1'b0;
        repeat (4) @(negedge vga_clk);
    endtask

    // Entry tick: airborne must still be low in the tick cycle and high one cycle later.
    task automatic entry_tick(input string tag);
        @(negedge vga_clk);
        vs = 1'b1;
        #1 check({tag, "_pre_air"}, {31'b0, airborne}, 32'd0);
        @(negedge vga_clk);
        #1 check({tag, "_entry_air"}, {31'b0, airborne}, 32'd1);
        check({tag, "_entry_top"}, {23'b0, dino_top}, 32'd368);
        repeat (2) @(negedge vga_clk);
        vs = 1'b0;
        repeat (3) @(negedge vga_clk);
    endtask

    task automatic pixel(input logic [8:0] r, input logic [9:0] c, output logic p);
        row_addr = r;
        col_addr = c;
        #1 p = px_dinosaur;
    endtask

    task automatic read_row(input logic [8:0] r, output logic [31:0] w);
        w = 32'h0;
        for (int c = 0; c < 32; c++) begin
            row_addr = r;
            col_addr = 10'(64 + c);
            #1 w[31 - c] = px_dinosaur;
        end
    endtask

    logic        p;
    logic [31:0] w;
    logic [31:0] leg_mid;

    initial begin
        clrn = 1'b0; vs = 1'b0; jump = 1'b0; freeze = 1'b0;
        rdn = 1'b0; row_addr = 9'd0; col_addr = 10'd0;
`ifdef DINO_LEG_ANIM_EN
        leg_mid = LEG_B;
`else
        leg_mid = LEG_A;
`endif

        // Reset held across a frame tick and a press.
        repeat (3) @(negedge vga_clk);
        #1 check("rst_top", {23'b0, dino_top}, 32'd368);
        check("rst_air", {31'b0, airborne}, 32'd0);
        press();
        do_tick();
        #1 check("rst_hold_top", {23'b0, dino_top}, 32'd368);
        check("rst_hold_air", {31'b0, airborne}, 32'd0);
        @(negedge vga_clk);
        clrn = 1'b1;
        repeat (2) @(negedge vga_clk);

        // Pixel bounds at height 0.
        read_row(9'd368, w);
        check("row368", w, ROW0);
        read_row(9'd399, w);
        check("row399_reset", w, LEG_A);
        pixel(9'd367, 10'd74, p);  check("row367", {31'b0, p}, 32'd0);
        pixel(9'd400, 10'd85, p);  check("row400", {31'b0, p}, 32'd0);
        pixel(9'd380, 10'd64, p);  check("col64_in", {31'b0, p}, 32'd1);
        pixel(9'd380, 10'd96, p);  check("col96", {31'b0, p}, 32'd0);
        pixel(9'd371, 10'd95, p);  check("col95_in", {31'b0, p}, 32'd1);
        pixel(9'd371, 10'd63, p);  check("col63", {31'b0, p}, 32'd0);
        rdn = 1'b1;
        pixel(9'd380, 10'd64, p);  check("rdn_a", {31'b0, p}, 32'd0);
        pixel(9'd371, 10'd95, p);  check("rdn_b", {31'b0, p}, 32'd0);
        rdn = 1'b0;

        // Idle leg animation over 16 ground ticks.
        for (int t = 1; t <= 16; t++) begin
            do_tick();
            if (t == 7 || t == 8 || t == 15 || t == 16) begin
                read_row(9'd399, w);
                check($sformatf("legs_t%0d", t), w,
                      (t == 8 || t == 15) ? leg_mid : LEG_A);
            end
        end
        check("idle_top", {23'b0, dino_top}, 32'd368);

        // Full trajectory.
        press();
        entry_tick("single");
        for (int i = 0; i < 14; i++) begin
            do_tick();
            #1 check($sformatf("rise%0d", i + 1), {23'b0, dino_top}, 32'(368 - rise_h[i]));
        end
        read_row(9'd263, w);
        check("apex_row0", w, ROW0);
        read_row(9'd294, w);
        check("apex_legs", w, LEG_A);
        for (int i = 0; i < 14; i++) begin
            do_tick();
            #1 check($sformatf("fall%0d", i + 1), {23'b0, dino_top}, 32'(368 - fall_h[i]));
            if (i == 12) check("air_before_land", {31'b0, airborne}, 32'd1);
        end
        check("landed_air", {31'b0, airborne}, 32'd0);

        // Second press at the apex is dropped.
        press();
        entry_tick("double");
        for (int i = 0; i < 14; i++) begin
            do_tick();
            #1 check($sformatf("d_rise%0d", i + 1), {23'b0, dino_top}, 32'(368 - rise_h[i]));
        end
        press();
        for (int i = 0; i < 14; i++) begin
            do_tick();
            #1 check($sformatf("d_fall%0d", i + 1), {23'b0, dino_top}, 32'(368 - fall_h[i]));
        end
        do_tick();
        #1 check("d_after_top", {23'b0, dino_top}, 32'd368);
        check("d_after_air", {31'b0, airborne}, 32'd0);

        // Freeze at height 50 for 10 frames, then resume with the same velocity.
        press();
        entry_tick("freeze");
        repeat (4) do_tick();
        #1 check("frz_h50", {23'b0, dino_top}, 32'd318);
        freeze = 1'b1;
        for (int t = 0; t < 10; t++) begin
            do_tick();
            #1 check($sformatf("frz_hold%0d", t), {23'b0, dino_top}, 32'd318);
        end
        check("frz_air", {31'b0, airborne}, 32'd1);
        freeze = 1'b0;
        do_tick();
        #1 check("frz_resume1", {23'b0, dino_top}, 32'd308);
        do_tick();
        #1 check("frz_resume2", {23'b0, dino_top}, 32'd299);

        // Asynchronous reset mid-jump, between clock edges.
        @(negedge vga_clk);
        #3 clrn = 1'b0;
        #1 check("async_top", {23'b0, dino_top}, 32'd368);
        check("async_air", {31'b0, airborne}, 32'd0);
        @(negedge vga_clk);
        clrn = 1'b1;
        repeat (2) @(negedge vga_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dinosaur_sprite.md
# dinosaur_sprite

Upstream pixel source for the VGA output stage. Holds the dinosaur's jump physics (ground/rise/fall state machine, updated once per frame during vertical blanking) and turns the VGA stage's registered `row_addr`/`col_addr` into `px_dinosaur` from a 32x32 bitmap ROM. Also exports the sprite's top row for the collision logic. The pixel output is combinational on the address inputs, so it lines up with the VGA stage's registered `rdn`.

## Interface
Parameters:
- `X0`, 64: leftmost sprite column (col_addr units).
- `GROUND_ROW`, 400: row just below the sprite's feet at height 0. Sprite occupies rows `GROUND_ROW-32-h .. GROUND_ROW-1-h`.
- `JUMP_V`, 14: initial upward velocity in px/frame. Must satisfy `JUMP_V*(JUMP_V+1)/2 <= 255` and `<= GROUND_ROW-32`.

Ports (clock is `vga_clk`; reset `clrn` is asynchronous, active-low):
- `vga_clk`  in  1  25 MHz pixel clock.
- `clrn`  in  1  asynchronous active-low reset.
- `row_addr`  in  9  current pixel row from the VGA stage.
- `col_addr`  in  10  current pixel column from the VGA stage.
- `rdn`  in  1  active-low display-enable from the VGA stage.
- `vs`  in  1  vertical sync from the VGA stage. Its rising edge is the frame tick.
- `jump`  in  1  asynchronous button level.
- `freeze`  in  1  game-over hold, synchronous.
- `px_dinosaur`  out  1  sprite pixel (combinational).
- `dino_top`  out  9  `GROUND_ROW-32-height`, registered.
- `airborne`  out  1  high when state is not GROUND, registered.

## Operation
- **Frame tick:** `vs` is registered once. `tick = vs & ~vs_q`, one cycle wide, once per frame.
- **Jump input:** `jump` passes through a 2-FF synchronizer, then a rising-edge detect.
  - An edge sets `pending`.
  - `pending` clears on every tick, after being sampled.
- **FSM state** (updated only on tick, and only when `freeze=0`):
  - `height` is 8-bit, `vel` is 5-bit. States are GROUND, RISE, FALL.
  - GROUND, with `pending`: go to RISE, `vel<=JUMP_V`. `height` stays 0 on this tick.
  - RISE: `height<=height+vel`, `vel<=vel-1`. If `vel==1`: go to FALL and set `vel<=1`.
  - FALL, `height<=vel`: `height<=0`, `vel<=0`, go to GROUND.
  - FALL, otherwise: `height<=height-vel`, `vel<=min(vel+1,JUMP_V)`.
- **Freeze and jump edge cases:**
  - `freeze=1` holds `height`, `vel`, state and the animation counter. `pending` still clears on tick.
  - A jump during RISE or FALL is dropped. There is no buffering.
- **Pixel:**
  - `px_dinosaur = ~rdn & in_box & rom[row_addr-top][31-(col_addr-X0)]`, where `top = dino_top`.
  - `in_box` means `top <= row_addr < top+32` and `X0 <= col_addr < X0+32`.
  - Compare as unsigned 10-bit values. Rows outside the box give 0; there is no wrap-around.
- **ROM:** 32 rows x 32 bits, MSB is the leftmost pixel.
  - Rows 0–25 are body.
  - Rows 26–31 are legs, with variant A and variant B (see Configuration).
- **Reset values:** state GROUND, `height=0`, `vel=0`, `pending=0`, sync/edge flops 0, leg phase 0.
  - `dino_top=GROUND_ROW-32`, `airborne=0`, `px_dinosaur` follows its combinational rule.
  - Reset mid-jump returns to all of the above immediately (asynchronous).

## Timing
- `px_dinosaur` has 0-cycle latency from `row_addr`/`col_addr`/`rdn`. No register is allowed on this path.
- `height`, `dino_top` and `airborne` change exactly 1 cycle after the tick cycle.
  - This falls in vertical blanking (`v_count` 2), so no tearing.
- Jump press to RISE: the press must reach `pending` (3 cycles of sync plus edge detect) before the tick. The first rise is applied on the tick after the one that enters RISE.
- Trajectory with `JUMP_V=14`:
  - 14 RISE ticks reach the apex at `height=105`.
  - 14 FALL ticks follow; the 14th lands at 0.
  - Total airborne time is 29 ticks, counting the entry tick.
- Simultaneous tick and `freeze` rising: freeze wins and no update happens that frame.

## Configuration
- **`DINO_LEG_ANIM_EN` defined:** a 3-bit frame counter counts ticks while in GROUND and `freeze=0`.
  - The leg phase toggles each time the counter wraps, i.e. every 8 ticks.
  - Rows 26–31 show variant A when phase is 0, variant B when phase is 1.
  - While airborne, variant A is always shown and the counter holds.
- **Not defined:** the counter and phase flop are absent. Variant A is always shown.

## Test plan
- **Reset values:** assert `clrn=0` mid-frame -> `dino_top=368`, `airborne=0`, state GROUND, all held until release.
- **Full trajectory:** one `jump` pulse, 60 frames -> `airborne` rises 1 cycle after the next tick. `dino_top` reaches its minimum of 263 after 14 further ticks, returns to 368 after 14 more, and `airborne` falls.
- **Double jump ignored:** second `jump` pulse at apex -> trajectory identical to the single-jump case; `pending` is 0 after the next tick.
- **Freeze:** `freeze=1` at `height=50` for 10 frames -> `dino_top=318` is constant. After `freeze=0`, the jump resumes with the same `vel`.
- **Pixel bounds at height 0:**
  - `row=367` or `row=400` -> 0.
  - `col=63` or `col=96` -> 0.
  - Interior points (e.g. `row=368`, `col=64..95`) match ROM row 0.
  - `rdn=1` -> 0 everywhere.
- **Leg animation (`DINO_LEG_ANIM_EN`):** idle on ground for 16 ticks -> row 399 shows variant B during ticks 8–15 and variant A again from tick 16. Without the macro, row 399 is always variant A.
